// File: rtl/sd_write.sv
// SPI-mode SD single-block writer (CMD24): command, R1 check, token, 512 payload bytes,
// dummy CRC, data-response check and busy wait. MISO is captured on the rising edge; everything else moves on the falling edge.
module sd_write #(
  parameter int R1_TO    = 2048,
  parameter int DRESP_TO = 64,
  parameter int BUSY_TO  = 1 << 20,
  parameter int GAP_CLKS = 8
) (
  input  logic        SD_clk,
  input  logic        SD_rst,
  input  logic        start,
  input  logic [31:0] sec_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_req,
  output logic        SD_cs,
  output logic        SD_datain,
  input  logic        SD_dataout,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_CMD    = 4'd1,
    ST_R1WAIT = 4'd2,
    ST_GAP    = 4'd3,
    ST_TOKEN  = 4'd4,
    ST_DATA   = 4'd5,
    ST_CRC    = 4'd6,
    ST_DRESP  = 4'd7,
    ST_BUSY   = 4'd8,
    ST_FINISH = 4'd9
  } state_t;

  localparam logic [20:0] R1_LIM    = 21'(R1_TO - 1);
  localparam logic [20:0] DRESP_LIM = 21'(DRESP_TO - 1);
  localparam logic [20:0] BUSY_LIM  = 21'(BUSY_TO - 1);
  localparam logic [5:0]  GAP_LAST  = 6'(GAP_CLKS - 1);
  localparam logic [39:0] ONES40    = '1;

  state_t      state_reg, state_next;
  logic        do_q;
  logic [5:0]  bit_cnt_reg, bit_cnt_next;
  logic [9:0]  byte_cnt_reg, byte_cnt_next;
  logic [47:0] tx_reg, tx_next;
  logic [7:0]  rx_reg, rx_next;
  logic [20:0] to_cnt_reg, to_cnt_next;
  logic        busy_reg, busy_next;
  logic        err_reg, err_next;

  always_ff @(posedge SD_clk or posedge SD_rst) begin
    if (SD_rst) do_q <= 1'b0;
    else        do_q <= SD_dataout;
  end

  always_ff @(negedge SD_clk or posedge SD_rst) begin
    if (SD_rst) begin
      state_reg    <= ST_IDLE;
      bit_cnt_reg  <= '0;
      byte_cnt_reg <= '0;
      tx_reg       <= '0;
      rx_reg       <= '0;
      to_cnt_reg   <= '0;
      busy_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      byte_cnt_reg <= byte_cnt_next;
      tx_reg       <= tx_next;
      rx_reg       <= rx_next;
      to_cnt_reg   <= to_cnt_next;
      busy_reg     <= busy_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    byte_cnt_next = byte_cnt_reg;
    tx_next       = tx_reg;
    rx_next       = rx_reg;
    to_cnt_next   = to_cnt_reg;
    busy_next     = busy_reg;
    err_next      = err_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          tx_next      = {8'h58, sec_addr, 8'hFF};
          bit_cnt_next = '0;
          busy_next    = 1'b1;
          err_next     = 1'b0;
          state_next   = ST_CMD;
        end
      end
      ST_CMD: begin
        tx_next = {tx_reg[46:0], 1'b1};
        if (bit_cnt_reg == 6'd47) begin
          bit_cnt_next = '0;
          to_cnt_next  = '0;
          rx_next      = '0;
          state_next   = ST_R1WAIT;
        end else begin
          bit_cnt_next = bit_cnt_reg + 6'd1;
        end
      end
      // bit_cnt == 0 means still hunting for the start bit
      ST_R1WAIT: begin
        if (bit_cnt_reg == 6'd0) begin
          if (!do_q) begin
            rx_next      = {rx_reg[6:0], 1'b0};
            bit_cnt_next = 6'd1;
          end else if (to_cnt_reg == R1_LIM) begin
            err_next   = 1'b1;
            state_next = ST_FINISH;
          end else begin
            to_cnt_next = to_cnt_reg + 21'd1;
          end
        end else begin
          rx_next = {rx_reg[6:0], do_q};
          if (bit_cnt_reg == 6'd7) begin
            bit_cnt_next = '0;
            if ({rx_reg[6:0], do_q} == 8'h00) begin
              state_next = ST_GAP;
            end else begin
              err_next   = 1'b1;
              state_next = ST_FINISH;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + 6'd1;
          end
        end
      end
      ST_GAP: begin
        if (bit_cnt_reg == GAP_LAST) begin
          tx_next      = {8'hFE, ONES40};
          bit_cnt_next = '0;
          state_next   = ST_TOKEN;
        end else begin
          bit_cnt_next = bit_cnt_reg + 6'd1;
        end
      end
      ST_TOKEN: begin
        tx_next = {tx_reg[46:0], 1'b1};
        if (bit_cnt_reg == 6'd7) begin
          tx_next       = {wr_data, ONES40};
          byte_cnt_next = '0;
          bit_cnt_next  = '0;
          state_next    = ST_DATA;
        end else begin
          bit_cnt_next = bit_cnt_reg + 6'd1;
        end
      end
      ST_DATA: begin
        tx_next = {tx_reg[46:0], 1'b1};
        if (bit_cnt_reg == 6'd7) begin
          bit_cnt_next = '0;
          if (byte_cnt_reg == 10'd511) begin
            state_next = ST_CRC;
          end else begin
            tx_next       = {wr_data, ONES40};
            byte_cnt_next = byte_cnt_reg + 10'd1;
          end
        end else begin
          bit_cnt_next = bit_cnt_reg + 6'd1;
        end
      end
      ST_CRC: begin
        if (bit_cnt_reg == 6'd15) begin
          bit_cnt_next = '0;
          to_cnt_next  = '0;
          rx_next      = '0;
          state_next   = ST_DRESP;
        end else begin
          bit_cnt_next = bit_cnt_reg + 6'd1;
        end
      end
      ST_DRESP: begin
        if (bit_cnt_reg == 6'd0) begin
          if (!do_q) begin
            rx_next      = {rx_reg[6:0], 1'b0};
            bit_cnt_next = 6'd1;
          end else if (to_cnt_reg == DRESP_LIM) begin
            err_next   = 1'b1;
            state_next = ST_FINISH;
          end else begin
            to_cnt_next = to_cnt_reg + 21'd1;
          end
        end else begin
          rx_next = {rx_reg[6:0], do_q};
          if (bit_cnt_reg == 6'd4) begin
            bit_cnt_next = '0;
            to_cnt_next  = '0;
            if ({rx_reg[3:0], do_q} == 5'b00101) begin
              state_next = ST_BUSY;
            end else begin
              err_next   = 1'b1;
              state_next = ST_FINISH;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + 6'd1;
          end
        end
      end
      ST_BUSY: begin
        bit_cnt_next = '0;
        if (do_q) begin
          state_next = ST_FINISH;
        end else if (to_cnt_reg == BUSY_LIM) begin
          err_next   = 1'b1;
          state_next = ST_FINISH;
        end else begin
          to_cnt_next = to_cnt_reg + 21'd1;
        end
      end
      ST_FINISH: begin
        if (bit_cnt_reg == 6'd7) begin
          bit_cnt_next = '0;
          busy_next    = 1'b0;
          state_next   = ST_IDLE;
        end else begin
          bit_cnt_next = bit_cnt_reg + 6'd1;
        end
      end
      default: begin
        bit_cnt_next = '0;
        state_next   = ST_IDLE;
      end
    endcase
  end

  // Outputs depend only on falling-edge registers, so they never move on the rising edge
  always_comb begin
    SD_cs     = 1'b1;
    SD_datain = 1'b1;
    case (state_reg)
      ST_CMD, ST_TOKEN, ST_DATA: begin
        SD_cs     = 1'b0;
        SD_datain = tx_reg[47];
      end
      ST_R1WAIT, ST_GAP, ST_CRC, ST_DRESP, ST_BUSY: SD_cs = 1'b0;
      default: ;
    endcase
  end

  assign wr_req = (bit_cnt_reg == 6'd7) &&
                  ((state_reg == ST_TOKEN) ||
                   ((state_reg == ST_DATA) && (byte_cnt_reg != 10'd511)));
  assign done   = (state_reg == ST_FINISH) && (bit_cnt_reg == 6'd7);
  assign busy   = busy_reg && !done;
  assign err    = err_reg;
  assign state  = state_reg;

endmodule

// File: tb/tb_sd_write.sv
// Directed bench for sd_write: a bit-level SD card model answers on MISO and records
// what it receives on MOSI; each step compares against hand-derived values.
module tb_sd_write;

  localparam int BUSY_TO_TB = 256;

  logic        SD_clk = 1'b0;
  logic        SD_rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] sec_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        SD_dataout = 1'b1;
  logic        wr_req, SD_cs, SD_datain, busy, done, err;
  logic [3:0]  state;

  sd_write #(.BUSY_TO(BUSY_TO_TB)) dut (
    .SD_clk(SD_clk), .SD_rst(SD_rst), .start(start), .sec_addr(sec_addr),
    .wr_data(wr_data), .wr_req(wr_req), .SD_cs(SD_cs), .SD_datain(SD_datain),
    .SD_dataout(SD_dataout), .busy(busy), .done(done), .err(err), .state(state)
  );

  always #5 SD_clk = ~SD_clk;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- card model ----------------
  typedef enum int {C_WCMD, C_CMD, C_R1DLY, C_R1, C_WTOK, C_DATA, C_CRC,
                    C_RESP, C_BUSY, C_END, C_HOLD} cst_t;
  cst_t        c_st = C_WCMD;
  int          c_cnt = 0;
  logic [47:0] c_sh;
  logic [7:0]  c_tmp, c_tok, c_byte, nb;
  logic [15:0] c_crc;
  logic        miso_nxt = 1'b1;
  logic [7:0]  r1_val = 8'h00;
  logic [7:0]  dresp_val = 8'hE5;
  int          busy_clks = 12;
  bit          r1_silent = 0;
  bit          busy_stuck = 0;
  logic [47:0] cmd_q[$];
  logic [7:0]  data_rx[512];
  logic [15:0] crc_rx;
  int          data_bytes = 0;

  always @(posedge SD_clk) begin
    if (SD_cs) begin
      c_st <= C_WCMD; c_cnt <= 0; miso_nxt <= 1'b1;
    end else begin
      case (c_st)
        C_WCMD: begin
          miso_nxt <= 1'b1;
          if (!SD_datain) begin c_sh <= 48'h0; c_cnt <= 1; c_st <= C_CMD; end
        end
        C_CMD: begin
          c_sh <= {c_sh[46:0], SD_datain};
          c_cnt <= c_cnt + 1;
          if (c_cnt == 47) begin
            cmd_q.push_back({c_sh[46:0], SD_datain});
            c_cnt <= 0;
            c_st <= r1_silent ? C_HOLD : C_R1DLY;
          end
        end
        C_R1DLY: begin
          miso_nxt <= 1'b1;
          c_cnt <= c_cnt + 1;
          if (c_cnt == 3) begin c_tmp <= r1_val; c_cnt <= 0; c_st <= C_R1; end
        end
        C_R1: begin
          miso_nxt <= c_tmp[7];
          c_tmp <= {c_tmp[6:0], 1'b1};
          c_cnt <= c_cnt + 1;
          if (c_cnt == 7) begin c_tok <= 8'hFF; c_cnt <= 0; c_st <= C_WTOK; end
        end
        C_WTOK: begin
          miso_nxt <= 1'b1;
          c_tok <= {c_tok[6:0], SD_datain};
          if ({c_tok[6:0], SD_datain} == 8'hFE) begin
            c_cnt <= 0; data_bytes <= 0; c_st <= C_DATA;
          end
        end
        C_DATA: begin
          nb = {c_byte[6:0], SD_datain};
          c_byte <= nb;
          if (c_cnt % 8 == 7) begin
            data_rx[c_cnt / 8] <= nb;
            data_bytes <= data_bytes + 1;
          end
          c_cnt <= c_cnt + 1;
          if (c_cnt == 4095) begin c_cnt <= 0; c_st <= C_CRC; end
        end
        C_CRC: begin
          c_crc <= {c_crc[14:0], SD_datain};
          c_cnt <= c_cnt + 1;
          if (c_cnt == 15) begin
            crc_rx <= {c_crc[14:0], SD_datain};
            c_tmp <= dresp_val; c_cnt <= 0; c_st <= C_RESP;
          end
        end
        C_RESP: begin
          miso_nxt <= c_tmp[7];
          c_tmp <= {c_tmp[6:0], 1'b1};
          c_cnt <= c_cnt + 1;
          if (c_cnt == 7) begin c_cnt <= 0; c_st <= C_BUSY; end
        end
        C_BUSY: begin
          if (!busy_stuck && c_cnt == busy_clks) begin
            miso_nxt <= 1'b1; c_st <= C_END;
          end else begin
            miso_nxt <= 1'b0; c_cnt <= c_cnt + 1;
          end
        end
        default: miso_nxt <= 1'b1;
      endcase
    end
  end

  always @(negedge SD_clk) SD_dataout <= miso_nxt;

  // ---------------- host-side monitor / payload source ----------------
  int         wr_cnt_blk = 0;
  int         wr_total = 0;
  int         stray_req = 0;
  int         done_cnt = 0;
  logic       done_err = 1'b0;
  int         cs_run = 0;
  int         done_cs_run = 0;
  int         st_cycles[16];
  logic [7:0] pat_xor = 8'h00;
  logic [31:0] idx_v;

  always @(posedge SD_clk) begin
    if (wr_req) begin
      idx_v = 32'(wr_cnt_blk);
      wr_data = idx_v[7:0] ^ pat_xor;
      wr_cnt_blk++;
      wr_total++;
      if (state != 4'd4 && state != 4'd5) stray_req++;
    end
    cs_run = SD_cs ? cs_run + 1 : 0;
    if (done) begin done_cnt++; done_err = err; done_cs_run = cs_run; end
    st_cycles[state]++;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats(input logic [7:0] px);
    wr_cnt_blk = 0;
    pat_xor = px;
    data_bytes = 0;
    foreach (st_cycles[i]) st_cycles[i] = 0;
  endtask

  task automatic launch(input string tag, input logic [31:0] addr, input bit hold);
    int n = 0;
    @(posedge SD_clk); #1;
    sec_addr = addr;
    start = 1'b1;
    while (!busy && n < 10) begin @(posedge SD_clk); #1; n++; end
    check({tag, "_accepted"}, 64'(busy), 64'd1);
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin @(posedge SD_clk); #1; n++; end
    check({tag, "_done_seen"}, 64'(done_cnt > d0), 64'd1);
  endtask

  task automatic check_block(input string tag, input logic [31:0] addr, input logic [7:0] px);
    int nbad = 0;
    logic [31:0] iv;
    for (int i = 0; i < 512; i++) begin
      iv = 32'(i);
      if (data_rx[i] !== (iv[7:0] ^ px)) nbad++;
    end
    check({tag, "_cmd"}, 64'(cmd_q[$]), 64'({8'h58, addr, 8'hFF}));
    check({tag, "_bad_bytes"}, 64'(nbad), 64'd0);
    check({tag, "_nbytes"}, 64'(data_bytes), 64'd512);
    check({tag, "_crc"}, 64'(crc_rx), 64'hFFFF);
    check({tag, "_done_err"}, 64'(done_err), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  int d_before, q_before, w_before, n;

  initial begin
    #1;
    check("rst_cs", 64'(SD_cs), 64'd1);
    check("rst_mosi", 64'(SD_datain), 64'd1);
    check("rst_wr_req", 64'(wr_req), 64'd0);
    check("rst_busy_done_err", 64'({busy, done, err}), 64'd0);
    check("rst_state", 64'(state), 64'd0);
    repeat (3) @(posedge SD_clk);
    #1 SD_rst = 1'b0;

    // Nominal block
    clear_stats(8'h00);
    launch("nom", 32'h0000_A7F8, 0);
    wait_done("nom", 6000);
    check_block("nom", 32'h0000_A7F8, 8'h00);
    check("nom_wr_req", 64'(wr_cnt_blk), 64'd512);
    check("nom_cs_before_done", 64'(done_cs_run), 64'd8);
    check("nom_cmd_clks", 64'(st_cycles[1]), 64'd48);
    check("nom_gap_clks", 64'(st_cycles[3]), 64'd8);
    check("nom_token_clks", 64'(st_cycles[4]), 64'd8);
    check("nom_data_clks", 64'(st_cycles[5]), 64'd4096);
    check("nom_crc_clks", 64'(st_cycles[6]), 64'd16);
    check("nom_busy_clks", 64'(st_cycles[8]), 64'd13);
    check("nom_finish_clks", 64'(st_cycles[9]), 64'd8);
    @(posedge SD_clk); #1;
    check("nom_idle_after", 64'({state, busy, SD_cs}), 64'({4'd0, 1'b0, 1'b1}));

    // R1 error
    r1_val = 8'h04;
    clear_stats(8'h00);
    launch("r1err", 32'h0000_0010, 0);
    wait_done("r1err", 500);
    check("r1err_err", 64'(done_err), 64'd1);
    check("r1err_wr_req", 64'(wr_cnt_blk), 64'd0);
    check("r1err_token_clks", 64'(st_cycles[4]), 64'd0);
    check("r1err_cs_before_done", 64'(done_cs_run), 64'd8);
    repeat (3) @(posedge SD_clk); #1;
    check("r1err_err_held", 64'({err, SD_cs}), 64'd3);
    r1_val = 8'h00;

    // Data rejected (CRC error token)
    dresp_val = 8'hEB;
    clear_stats(8'h3C);
    launch("rej", 32'h0001_0000, 0);
    @(posedge SD_clk); #1;
    check("rej_err_cleared", 64'(err), 64'd0);
    wait_done("rej", 6000);
    check("rej_err", 64'(done_err), 64'd1);
    check("rej_busy_skipped", 64'(st_cycles[8]), 64'd0);
    check("rej_finish_clks", 64'(st_cycles[9]), 64'd8);
    check("rej_wr_req", 64'(wr_cnt_blk), 64'd512);
    dresp_val = 8'hE5;

    // R1 timeout: MISO stuck high
    r1_silent = 1;
    clear_stats(8'h00);
    launch("r1to", 32'h0000_0020, 0);
    wait_done("r1to", 3000);
    check("r1to_err", 64'(done_err), 64'd1);
    check("r1to_wait_clks", 64'(st_cycles[2]), 64'd2048);
    check("r1to_finish_clks", 64'(st_cycles[9]), 64'd8);
    check("r1to_wr_req", 64'(wr_cnt_blk), 64'd0);
    r1_silent = 0;

    // Busy timeout: MISO stuck low
    busy_stuck = 1;
    clear_stats(8'h00);
    launch("busyto", 32'h0000_0030, 0);
    wait_done("busyto", 6000);
    check("busyto_err", 64'(done_err), 64'd1);
    check("busyto_busy_clks", 64'(st_cycles[8]), 64'(BUSY_TO_TB));
    busy_stuck = 0;

    // Reset at data byte 200
    clear_stats(8'h00);
    launch("rstmid", 32'h1234_5678, 0);
    n = 0;
    while (wr_cnt_blk < 200 && n < 3000) begin @(posedge SD_clk); #1; n++; end
    check("rstmid_reached", 64'(wr_cnt_blk), 64'd200);
    d_before = done_cnt;
    #2 SD_rst = 1'b1;
    #1;
    check("rstmid_cs_async", 64'(SD_cs), 64'd1);
    check("rstmid_state", 64'({state, busy, wr_req}), 64'd0);
    repeat (3) @(posedge SD_clk);
    #1 SD_rst = 1'b0;
    repeat (20) @(posedge SD_clk);
    #1 check("rstmid_no_done", 64'(done_cnt), 64'(d_before));
    clear_stats(8'h5A);
    launch("after_rst", 32'hCAFE_0001, 0);
    wait_done("after_rst", 6000);
    check_block("after_rst", 32'hCAFE_0001, 8'h5A);

    // start pulsed during DATA is ignored
    clear_stats(8'hA5);
    d_before = done_cnt;
    q_before = cmd_q.size();
    launch("ign", 32'h0000_0777, 0);
    n = 0;
    while (wr_cnt_blk < 100 && n < 3000) begin @(posedge SD_clk); #1; n++; end
    sec_addr = 32'h0000_0999;
    start = 1'b1;
    repeat (2) @(posedge SD_clk);
    #1 start = 1'b0;
    wait_done("ign", 6000);
    repeat (60) @(posedge SD_clk);
    #1;
    check("ign_one_done", 64'(done_cnt - d_before), 64'd1);
    check("ign_one_cmd", 64'(cmd_q.size() - q_before), 64'd1);
    check_block("ign", 32'h0000_0777, 8'hA5);

    // Back-to-back: start held high across done
    clear_stats(8'h00);
    d_before = done_cnt;
    q_before = cmd_q.size();
    w_before = wr_total;
    launch("b2b", 32'h0BAD_F00D, 1);
    sec_addr = 32'h0000_0042;
    wait_done("b2b_first", 6000);
    n = 0;
    while (state != 4'd1 && n < 10) begin @(posedge SD_clk); #1; n++; end
    check("b2b_restart", 64'(state), 64'd1);
    start = 1'b0;
    wait_done("b2b_second", 6000);
    check("b2b_dones", 64'(done_cnt - d_before), 64'd2);
    check("b2b_cmds", 64'(cmd_q.size() - q_before), 64'd2);
    check("b2b_first_addr", 64'(cmd_q[q_before]), 64'({8'h58, 32'h0BAD_F00D, 8'hFF}));
    check("b2b_wr_req", 64'(wr_total - w_before), 64'd1024);
    check_block("b2b_second", 32'h0000_0042, 8'h00);

    check("stray_wr_req", 64'(stray_req), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/sd_write.md
SD_WRITE -- requirements
Module: sd_write

Interface
REQ-001 SD_clk  in  1  SPI SCK and logic clock; card samples MOSI on rising edge.
REQ-002 SD_rst  in  1  asynchronous, active-high reset.
REQ-003 start  in  1  block-write request; sampled on SD_clk falling edge, accepted only in IDLE.
REQ-004 sec_addr  in  32  sector address; captured on the falling edge that accepts start.
REQ-005 wr_data  in  8  payload byte; sampled at the falling edge following a wr_req cycle.
REQ-006 wr_req  out  1  one-cycle next-byte request; exactly 512 pulses per block.
REQ-007 SD_cs  out  1  card chip select, active-low.
REQ-008 SD_datain  out  1  MOSI, MSB first.
REQ-009 SD_dataout  in  1  MISO.
REQ-010 busy  out  1  high from start acceptance until done.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 err  out  1  block-failure flag; valid with done; held until next accepted start.
REQ-013 state  out  4  current FSM state code, per REQ-016.

Function
REQ-014 Timing: SD_dataout is registered on SD_clk rising edge (do_q); the FSM, all outputs and wr_data sampling update on the SD_clk falling edge, using do_q.
REQ-015 Parameters: R1_TO=2048 clocks, DRESP_TO=64 clocks, BUSY_TO=2^20 clocks, GAP=8 clocks.
REQ-016 States/codes: IDLE=0, CMD=1, R1WAIT=2, GAP=3, TOKEN=4, DATA=5, CRC=6, DRESP=7, BUSY=8, FINISH=9; any other code returns to IDLE next cycle.
REQ-017 IDLE: SD_cs=1, SD_datain=1; on start: latch sec_addr, busy=1, err=0, go CMD.
REQ-018 CMD: SD_cs=0; shift 48 bits {8'h58, sec_addr[31:24..7:0], 8'hFF} MSB first, one bit per clock; after bit 47 go R1WAIT.
REQ-019 R1WAIT: SD_datain=1; wait for do_q=0 (R1 start bit), shift it plus the next 7 bits; R1==8'h00 -> GAP, otherwise err=1 -> FINISH; no start bit within R1_TO clocks -> err=1 -> FINISH.
REQ-020 GAP: SD_datain=1 for 8 clocks, then TOKEN.
REQ-021 TOKEN: drive 8'hFE MSB first; wr_req=1 during the cycle driving its bit 0; then DATA.
REQ-022 DATA: for byte n (0..511) drive wr_data sampled at the byte's first (bit 7) cycle; wr_req=1 during bit 0 of bytes 0..510 only; byte counter 10 bits, no wrap; after byte 511 bit 0 go CRC.
REQ-023 CRC: drive 16 bits of 1 (dummy CRC), then DRESP.
REQ-024 DRESP: SD_datain=1; wait for do_q=0, capture 5 bits (start bit included); 5'b00101 -> BUSY, any other -> err=1 -> FINISH; no start bit within DRESP_TO -> err=1 -> FINISH.
REQ-025 BUSY: SD_datain=1, SD_cs=0; wait for do_q=1 -> FINISH; exceeding BUSY_TO -> err=1 -> FINISH.
REQ-026 FINISH: SD_cs=1, SD_datain=1 for 8 clocks; on the 8th: done=1 for one cycle, busy=0, -> IDLE.
REQ-027 start while busy=1 is ignored (no queuing); start held high after done restarts on the next IDLE cycle.
REQ-028 wr_req never asserts outside TOKEN/DATA; on any error path no further wr_req pulses occur.
REQ-029 Error exits always pass through FINISH; done is pulsed on every accepted start, success or failure.

Reset
REQ-030 SD_rst=1 forces immediately: state=IDLE, SD_cs=1, SD_datain=1, wr_req=0, busy=0, done=0, err=0, all counters/shifters 0.
REQ-031 Reset mid-transfer aborts without done; first start after release begins a fresh CMD.

Verification
REQ-032 Nominal: sec_addr=32'h0000_A7F8, card model R1=00, resp 0x05, 12 busy clocks, wr_data=n[7:0] -> MOSI shows 58 00 00 A7 F8 FF, FE, 512 bytes 00..FF 00..FF, FF FF; 512 wr_req pulses; done=1, err=0; CS high 8 clocks before done.
REQ-033 R1 error: card answers R1=0x04 -> no token sent, zero wr_req pulses, err=1 with done, CS high.
REQ-034 Data rejected: response token 0x0B (CRC error) -> err=1, BUSY skipped, done after 8 FINISH clocks.
REQ-035 Timeouts: MISO stuck high after CMD -> err=1 at R1_TO+8 clocks; MISO stuck low in BUSY -> err=1 after BUSY_TO.
REQ-036 Reset at DATA byte 200 -> SD_cs=1 asynchronously, no done; next start writes full block correctly.
REQ-037 start pulsed during DATA -> ignored; exactly one done; back-to-back start held high -> two complete blocks, sectors captured at each acceptance.
